// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory read channel plus the held-instruction
// handshake toward decode. The fetch unit is the master of both channels.
interface fetch_unit_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ready;
    logic              imem_rvalid;
    logic [31:0]       imem_rdata;

    logic              inst_valid;
    logic              inst_ready;
    logic [31:0]       inst;
    logic [ADDR_W-1:0] inst_pc;
    logic [5:0]        opcode;
    logic [5:0]        func;

    modport master (
        output imem_req, imem_addr,
        input  imem_ready, imem_rvalid, imem_rdata,
        output inst_valid, inst, inst_pc, opcode, func,
        input  inst_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ready, imem_rvalid, imem_rdata,
        input  inst_valid, inst, inst_pc, opcode, func,
        output inst_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-outstanding reads to
// instruction memory and holds each fetched word until decode takes it.
//
// state | meaning
// FETCH | request pending at imem_addr = pc
// WAIT  | request accepted, response outstanding (drop = discard it)
// HOLD  | instruction presented to decode (inst_valid = 1)
// STOP  | CU halted; no further fetches until reset
module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
    input  logic              clk,
    input  logic              rst_b,
    fetch_unit_if.master      bus,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halted,
    output logic              stopped
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              drop_q, drop_d;
    logic              halt_q, halt_d;
    logic              capture;

    logic              req_q;
    logic [ADDR_W-1:0] addr_q;
    logic              valid_q;
    logic              stopped_q;
    logic [31:0]       inst_q;
    logic [ADDR_W-1:0] inst_pc_q;

    logic              accepted;
    logic              consumed;
    logic [ADDR_W-1:0] redirect_tgt;

    assign accepted     = req_q & bus.imem_ready;
    assign consumed     = valid_q & bus.inst_ready;
    assign redirect_tgt = redirect_pc & ~ADDR_W'(3);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        halt_d  = halt_q;
        capture = 1'b0;
        case (state_q)
            S_FETCH: begin
                // A request the memory took this cycle must still be drained.
                if (halted) begin
                    if (accepted) begin
                        state_d = S_WAIT;
                        drop_d  = 1'b1;
                        halt_d  = 1'b1;
                    end else begin
                        state_d = S_STOP;
                    end
                end else if (redirect_valid) begin
                    pc_d = redirect_tgt;
                    if (accepted) begin
                        state_d = S_WAIT;
                        drop_d  = 1'b1;
                    end
                end else if (accepted) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (halted || halt_q) begin
                    halt_d = 1'b1;
                    if (bus.imem_rvalid) begin
                        state_d = S_STOP;
                        drop_d  = 1'b0;
                    end
                end else if (redirect_valid) begin
                    pc_d = redirect_tgt;
                    if (bus.imem_rvalid) begin
                        state_d = S_FETCH;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (bus.imem_rvalid) begin
                    drop_d = 1'b0;
                    if (drop_q) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_HOLD;
                        capture = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (halted) begin
                    state_d = S_STOP;
                end else if (redirect_valid) begin
                    pc_d    = redirect_tgt;
                    state_d = S_FETCH;
                end else if (consumed) begin
                    pc_d    = pc_q + ADDR_W'(4);
                    state_d = S_FETCH;
                end
            end
            S_STOP: begin
                state_d = S_STOP;
            end
            default: begin
                state_d = S_STOP;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= S_FETCH;
            pc_q    <= PC_RESET;
            drop_q  <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            halt_q  <= halt_d;
        end
    end

    // Outputs are registered from next-state so they line up with the state.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            req_q     <= 1'b0;
            addr_q    <= PC_RESET;
            valid_q   <= 1'b0;
            stopped_q <= 1'b0;
            inst_q    <= '0;
            inst_pc_q <= '0;
        end else begin
            req_q     <= (state_d == S_FETCH);
            addr_q    <= pc_d;
            valid_q   <= (state_d == S_HOLD);
            stopped_q <= (state_d == S_STOP);
            if (capture) begin
                inst_q    <= bus.imem_rdata;
                inst_pc_q <= pc_q;
            end
        end
    end

    assign bus.imem_req   = req_q;
    assign bus.imem_addr  = addr_q;
    assign bus.inst_valid = valid_q;
    assign bus.inst       = inst_q;
    assign bus.inst_pc    = inst_pc_q;
    assign bus.opcode     = inst_q[31:26];
    assign bus.func       = inst_q[5:0];
    assign stopped        = stopped_q;

endmodule
